// File: rtl/matrix_scan_driver_pkg.sv
// Shared constants, scan state encoding and row-select helper for the LED matrix scanner.
package matrix_scan_driver_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 16;
    localparam int unsigned FRAME_W     = MATRIX_ROWS * MATRIX_COLS;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    // Active-low one-cold row select: only the addressed row is pulled low.
    function automatic logic [MATRIX_ROWS-1:0] row_onehot_n(input logic [2:0] row);
        logic [MATRIX_ROWS-1:0] sel;
        sel      = '1;
        sel[row] = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_row_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module matrix_row_timer #(
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed 8x16 LED matrix scanner with double-buffered frames and inter-row blanking.
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned ROWS         = MATRIX_ROWS,
    parameter int unsigned COLS         = MATRIX_COLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [ROWS*COLS-1:0]       frame_data,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic                       frame_done,
    output logic [$clog2(ROWS)-1:0]    cur_row,
    output logic [ROWS-1:0]            MATRIX_ROW,
    output logic [COLS-1:0]            MATRIX_COL
);

    localparam int unsigned RowW      = $clog2(ROWS);
    localparam int unsigned FrameW    = ROWS * COLS;
    localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                       : BLANK_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);
    localparam logic [RowW-1:0] LastRow   = RowW'(ROWS - 1);

    scan_state_e       state_q, state_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [FrameW-1:0] pending_q, pending_d;
    logic [FrameW-1:0] active_q, active_d;
    logic              pending_full_q, pending_full_d;
    logic [ROWS-1:0]   mat_row_q, mat_row_d;
    logic [COLS-1:0]   mat_col_q, mat_col_d;

    logic              timer_load;
    logic [CntW-1:0]   timer_val;
    logic              timer_zero;
    logic              promote;
    logic              accept;

    matrix_row_timer #(
        .Width (CntW)
    ) u_row_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Held low throughout reset so nothing is accepted while rst is asserted.
    assign frame_ready = ~pending_full_q & ~rst;
    assign accept      = frame_valid & frame_ready;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        timer_load = 1'b0;
        timer_val  = BlankLoad;
        promote    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                row_d   = '0;
                promote = pending_full_q;
                if (enable) begin
                    state_d    = StBlank;
                    timer_load = 1'b1;
                    timer_val  = BlankLoad;
                end
            end
            StBlank: begin
                if (!enable) begin
                    state_d = StIdle;
                    row_d   = '0;
                end else if (timer_zero) begin
                    state_d    = StDrive;
                    timer_load = 1'b1;
                    timer_val  = DwellLoad;
                end
            end
            StDrive: begin
                if (!enable) begin
                    state_d = StIdle;
                    row_d   = '0;
                end else if (timer_zero) begin
                    state_d    = StBlank;
                    timer_load = 1'b1;
                    timer_val  = BlankLoad;
                    if (row_q == LastRow) begin
                        frame_done = 1'b1;
                        promote    = pending_full_q;
                        row_d      = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so the pins change on the state edge.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (promote) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (accept) begin
            pending_d      = frame_data;
            pending_full_d = 1'b1;
        end
        mat_row_d = '1;
        mat_col_d = '1;
        if (state_d == StDrive) begin
            mat_row_d = row_onehot_n(row_d);
            mat_col_d = ~active_d[row_d*COLS +: COLS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            row_q          <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            mat_row_q      <= '1;
            mat_col_q      <= '1;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            mat_row_q      <= mat_row_d;
            mat_col_q      <= mat_col_d;
        end
    end

    assign cur_row    = row_q;
    assign MATRIX_ROW = mat_row_q;
    assign MATRIX_COL = mat_col_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench: a timeline-based reference model queues expected pin values every cycle.
module tb_matrix_scan_driver;

    localparam int unsigned Dwell       = 4;
    localparam int unsigned Blank       = 2;
    localparam int unsigned Rows        = 8;
    localparam int unsigned Cols        = 16;
    localparam int unsigned FrameW      = Rows * Cols;
    localparam int          RowPeriod   = Dwell + Blank;
    localparam int          FramePeriod = RowPeriod * Rows;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [FrameW-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;
    logic              frame_done;
    logic [2:0]        cur_row;
    logic [Rows-1:0]   mrow;
    logic [Cols-1:0]   mcol;

    typedef struct packed {
        logic [7:0]  row;
        logic [15:0] col;
        logic        done;
        logic        ready;
        logic [2:0]  cur;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    always #5 clk = ~clk;

    matrix_scan_driver #(
        .DWELL_CYCLES (Dwell),
        .BLANK_CYCLES (Blank),
        .ROWS         (Rows),
        .COLS         (Cols)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .cur_row     (cur_row),
        .MATRIX_ROW  (mrow),
        .MATRIX_COL  (mcol)
    );

    // Reference model: m_t counts cycles since the scan left idle; position in the
    // 48-cycle frame timeline gives row, blank/drive phase and frame boundary.
    bit                m_run       = 1'b0;
    bit                m_pend_full = 1'b0;
    bit                m_acc;
    bit                m_prom;
    int                m_t         = 0;
    logic [FrameW-1:0] m_disp      = '0;
    logic [FrameW-1:0] m_pend      = '0;

    function automatic obs_t expect_now();
        obs_t o;
        int   p;
        int   r;
        o.row   = '1;
        o.col   = '1;
        o.done  = 1'b0;
        o.cur   = '0;
        o.ready = !m_pend_full && !rst;
        if (m_run) begin
            p     = m_t % FramePeriod;
            r     = p / RowPeriod;
            o.cur = 3'(r);
            if ((p % RowPeriod) >= Blank) begin
                o.row = ~(8'(1) << r);
                o.col = ~m_disp[r*Cols +: Cols];
            end
            o.done = (p == FramePeriod - 1) && enable;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            m_run       = 1'b0;
            m_t         = 0;
            m_disp      = '0;
            m_pend_full = 1'b0;
        end else begin
            m_acc  = frame_valid && !m_pend_full;
            m_prom = 1'b0;
            if (!m_run) begin
                m_prom = m_pend_full;
                if (enable) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else if (!enable) begin
                m_run = 1'b0;
            end else begin
                m_prom = m_pend_full && ((m_t % FramePeriod) == FramePeriod - 1);
                m_t++;
            end
            if (m_prom) begin
                m_disp      = m_pend;
                m_pend_full = 1'b0;
            end else if (m_acc) begin
                m_pend      = frame_data;
                m_pend_full = 1'b1;
            end
        end
        #2;
        exp_q.push_back(expect_now());
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e       = exp_q.pop_front();
            a.row   = mrow;
            a.col   = mcol;
            a.done  = frame_done;
            a.ready = frame_ready;
            a.cur   = cur_row;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL scan cycle %0d: got row=%h col=%h done=%b ready=%b cur_row=%0d, want row=%h col=%h done=%b ready=%b cur_row=%0d",
                         cycle, a.row, a.col, a.done, a.ready, a.cur,
                         e.row, e.col, e.done, e.ready, e.cur);
            end
        end
    end

    function automatic logic [FrameW-1:0] rand_frame();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [FrameW-1:0] d);
        frame_data  = d;
        frame_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_ready) begin
                tick(1);
                frame_valid = 1'b0;
                return;
            end
            tick(1);
        end
        frame_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL accept timeout: frame_ready stayed 0, want 1 within 200 cycles");
    endtask

    // Waits for a DRIVE cycle on a row in [lo, hi]; timing only, expectations come from the model.
    task automatic wait_drive(input int lo, input int hi);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mrow != 8'hFF && int'(cur_row) >= lo && int'(cur_row) <= hi) begin
                tick(1);
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL drive wait: no drive on rows %0d..%0d, want one within 200 cycles", lo, hi);
    endtask

    initial begin
        logic [FrameW-1:0] fa;
        rst         = 1'b1;
        enable      = 1'b0;
        frame_valid = 1'b1;
        frame_data  = rand_frame();
        tick(3);

        vectors++;
        if (mrow !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset: got MATRIX_ROW=%h, want ff", mrow);
        end
        vectors++;
        if (mcol !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset: got MATRIX_COL=%h, want ffff", mcol);
        end
        vectors++;
        if (frame_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got frame_ready=%b, want 0", frame_ready);
        end

        rst         = 1'b0;
        frame_valid = 1'b0;

        fa                 = '0;
        fa[15:0]           = 16'h0001;
        fa[FrameW-1 -: 16] = 16'h8000;
        send_frame(fa);
        tick(2);
        enable = 1'b1;
        tick(20);

        // Frame B mid-scan, then hammer frame_valid with changing data while pending is full.
        send_frame(rand_frame());
        frame_valid = 1'b1;
        repeat (10) begin
            frame_data = rand_frame();
            tick(1);
        end
        frame_valid = 1'b0;
        tick(2 * FramePeriod);

        wait_drive(3, 3);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(FramePeriod + 12);

        repeat (600) begin
            if ($urandom_range(63) == 0) enable = ~enable;
            rst         = ($urandom_range(255) == 0);
            frame_valid = ($urandom_range(3) == 0);
            frame_data  = rand_frame();
            tick(1);
        end
        rst         = 1'b0;
        frame_valid = 1'b0;
        enable      = 1'b1;
        tick(2);

        // Reset mid-DRIVE with a frame pending: scan must stay dark afterwards.
        send_frame(rand_frame());
        wait_drive(0, 6);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(FramePeriod + 12);

        vectors++;
        if (mcol !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL post-reset scan: got MATRIX_COL=%h, want ffff", mcol);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
- Row-multiplexed scanner for the 8x16 LED matrix; sits directly downstream of the snake game controller and drives the MATRIX_ROW / MATRIX_COL board pins.
- Accepts whole frames over a valid/ready handshake into a pending buffer. The pending frame is promoted to the displayed frame only at a frame boundary, so the matrix never shows a half-updated frame.
- Inserts a blanking gap between rows to suppress ghosting.

Parameters:
- DWELL_CYCLES, 1024: clk cycles each row is driven.
- BLANK_CYCLES, 16: clk cycles with all rows off before each row is driven; must be at least 1.
- ROWS, 8: matrix rows.
- COLS, 16: matrix columns.

Ports:
- clk  in  1  system clock (MCLK at top level).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low blanks the matrix.
- frame_data  in  ROWS*COLS  pixel bit [r*COLS+c] is row r, column c; 1 = lit.
- frame_valid  in  1  frame_data is valid.
- frame_ready  out  1  pending buffer is empty.
- frame_done  out  1  one-cycle pulse at end of row ROWS-1.
- cur_row  out  3  row currently scanned (debug).
- MATRIX_ROW  out  ROWS  active-low row select.
- MATRIX_COL  out  COLS  active-low column drive.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port rst.
- Reset values:
  - MATRIX_ROW = all ones, MATRIX_COL = all ones.
  - frame_done = 0, cur_row = 0, state = IDLE.
  - Active frame = 0, pending buffer empty.
  - frame_ready = 0 while rst is high; 1 on the first cycle after rst deasserts.
- frame_ready = !pending_full (registered flag). A frame is accepted on any cycle with frame_valid && frame_ready: frame_data is copied into pending and pending_full is set. While pending is full, frame_valid is ignored and frame_data may change freely.
- Timing: one down-counter, reloaded to BLANK_CYCLES-1 or DWELL_CYCLES-1 on each state entry. A row period is BLANK_CYCLES + DWELL_CYCLES cycles.
- States:
  - IDLE: all outputs blank, row = 0. If pending is full, promote it to active. When enable is high, go to BLANK.
  - BLANK: MATRIX_ROW = all ones, MATRIX_COL = all ones. When the counter reaches 0, go to DRIVE.
  - DRIVE: MATRIX_ROW bit [row] = 0, all other bits 1. MATRIX_COL = ~active[row*COLS +: COLS]. When the counter reaches 0:
    - If row == ROWS-1: pulse frame_done, promote pending to active if pending is full, set row = 0.
    - Otherwise: row = row + 1.
    - Then go to BLANK.
- Promotion: active <= pending and pending_full <= 0 in the same cycle; frame_ready rises on the next cycle. Acceptance and promotion cannot coincide because frame_ready is low whenever pending is full.
- enable low in BLANK or DRIVE: next edge enters IDLE. Outputs blank from that edge, row resets to 0, pending contents are kept. No frame_done pulse.
- All matrix outputs are registered. Latency from enable rising to the first lit row is 1 + BLANK_CYCLES cycles.
- Row wrap: after ROWS-1 the scan returns to row 0 with no extra gap beyond the normal blank.
- Column width rule: the column slice is taken from the active frame only and never from pending or frame_data.

Decomposition:
- Shared package holds:
  - Constants MATRIX_ROWS=8, MATRIX_COLS=16, FRAME_W=128.
  - State encoding IDLE/BLANK/DRIVE.
  - Function row_onehot_n(row) returning the active-low row select.
- One natural sub-module: matrix_row_timer, the loadable down-counter with a zero flag. It is shared with future brightness/PWM work.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2):
- Reset held 3 cycles with frame_valid=1 -> MATRIX_ROW=8'hFF, MATRIX_COL=16'hFFFF, frame_ready=0, no acceptance.
- Load a frame with row0=16'h0001 and row7=16'h8000, then enable=1:
  - Cycles 1-2 after enable are blank.
  - Row 0 is then driven for 4 cycles with MATRIX_ROW=8'hFE, MATRIX_COL=16'hFFFE.
  - Row 7 is driven with MATRIX_ROW=8'h7F, MATRIX_COL=16'h7FFF.
  - The frame period is 48 cycles.
- Present frame B mid-scan of frame A:
  - B is accepted and frame_ready drops.
  - Frame A is displayed until frame_done.
  - Row 0 of the next scan shows B's data.
  - frame_ready returns to 1 one cycle after frame_done.
- Hold frame_valid with pending full and change frame_data -> the pending contents are unchanged at promotion.
- Deassert enable during row 3 DRIVE -> next cycle outputs are FF/FFFF, cur_row=0, no frame_done. Re-enable -> the scan restarts at row 0 after 2 blank cycles.
- Assert rst mid-DRIVE with pending full -> all reset values restored, pending emptied, and the active frame is zeroed (matrix stays dark when re-enabled).
